// File: rtl/mips_pkg.sv
// Types and constants shared by the fetch stage and the PC register.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, 1-entry decode buffer,
// redirect squashing of in-flight words, and sticky halt on a misaligned PC.
module instr_fetch #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_wen,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  output logic              fetch_fault
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              fault_q, fault_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] buf_instr_s;
  logic              can_accept_s;
  logic              req_ok_s;
  logic              redirect_s;

  // A request only goes out when the buffer has room, so a response never meets a full buffer.
  assign can_accept_s = !if_valid_q || id_ready;
  assign req_ok_s     = (state_q == REQ) && (pc[1:0] == 2'b00) && can_accept_s;
  assign redirect_s   = redirect && (state_q != HALT);

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    fault_d     = fault_q;
    if_valid_d  = if_valid_q && !id_ready;
    buf_instr_s = if_instr_q;
    if_pc_d     = if_pc_q;
    imem_req    = req_ok_s;
    imem_addr   = pc;
    pc_wen      = 1'b0;
    pc_next     = pc + PC_STEP;

    if (redirect_s) begin
      // Redirect beats everything; a granted or outstanding read becomes wrong-path.
      pc_wen     = 1'b1;
      pc_next    = redirect_pc;
      if_valid_d = 1'b0;
      if ((state_q == WAIT) && imem_rvalid) begin
        drop_d  = 1'b0;
        state_d = REQ;
      end else if ((state_q == WAIT) || (req_ok_s && imem_gnt)) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else if (req_ok_s && imem_gnt) begin
            pc_wen   = 1'b1;
            req_pc_d = pc;
            state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              if_valid_d  = 1'b1;
              buf_instr_s = imem_rdata;
              if_pc_d     = req_pc_q;
            end
          end else begin
            state_d = WAIT;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end

    if_instr_d = if_valid_d ? buf_instr_s : NOP_INSTR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      fault_q    <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC register in the loop.
module tb_instr_fetch;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_wen;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  instr_fetch dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .pc_next(pc_next), .pc_wen(pc_wen),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // External PC register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else if (pc_wen) pc <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    edge1();
    edge1();
    #1;
    chk("rst_if_valid", if_valid, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_fault", fetch_fault, 32'd0);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_pc_wen", pc_wen, 32'd0);
    chk("rst_pc_next", pc_next, 32'h0040_0004);
    reset_n = 1'b1;

    // 1: first fetch
    edge1();
    imem_gnt = 1'b1; #1;
    chk("t1_req", imem_req, 32'd1);
    chk("t1_addr", imem_addr, 32'h0040_0000);
    chk("t1_pc_wen", pc_wen, 32'd1);
    chk("t1_pc_next", pc_next, 32'h0040_0004);
    edge1();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005; #1;
    chk("t1_wait_req", imem_req, 32'd0);
    chk("t1_pc", pc, 32'h0040_0004);
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("t1_if_valid", if_valid, 32'd1);
    chk("t1_if_instr", if_instr, 32'h2008_0005);
    chk("t1_if_pc", if_pc, 32'h0040_0000);

    // 2: back-pressure
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_stall", imem_req, 32'd0);
      chk("t2_instr_stable", if_instr, 32'h2008_0005);
      edge1(); #1;
    end
    id_ready = 1'b1; #1;
    chk("t2_req_resume", imem_req, 32'd1);
    chk("t2_addr", imem_addr, 32'h0040_0004);
    edge1();
    imem_gnt = 1'b1; #1;
    chk("t2_consumed", if_valid, 32'd0);
    chk("t2_nop", if_instr, 32'h0);
    chk("t2_pc_next", pc_next, 32'h0040_0008);

    // 3: redirect in WAIT
    edge1();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0100; #1;
    chk("t3_pc_wen", pc_wen, 32'd1);
    chk("t3_pc_next", pc_next, 32'h0040_0100);
    edge1();
    redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("t3_pc", pc, 32'h0040_0100);
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("t3_dropped", if_valid, 32'd0);
    chk("t3_req", imem_req, 32'd1);
    chk("t3_addr", imem_addr, 32'h0040_0100);

    // 4: redirect with gnt
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0040_0200; #1;
    chk("t4_pc_wen", pc_wen, 32'd1);
    chk("t4_pc_next", pc_next, 32'h0040_0200);
    edge1();
    imem_gnt = 1'b0; redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBADC_0DE0; #1;
    chk("t4_wait_req", imem_req, 32'd0);
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("t4_dropped", if_valid, 32'd0);
    chk("t4_addr", imem_addr, 32'h0040_0200);
    id_ready = 1'b0; imem_gnt = 1'b1;
    edge1();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("t4_if_valid", if_valid, 32'd1);
    chk("t4_if_instr", if_instr, 32'h1111_1111);
    chk("t4_if_pc", if_pc, 32'h0040_0200);

    // redirect coinciding with rvalid: data discarded, no stale drop
    id_ready = 1'b1; imem_gnt = 1'b1;
    edge1();
    imem_gnt = 1'b0; id_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0040_0300; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    edge1();
    redirect = 1'b0; imem_rvalid = 1'b0; #1;
    chk("rr_if_valid", if_valid, 32'd0);
    chk("rr_req", imem_req, 32'd1);
    chk("rr_addr", imem_addr, 32'h0040_0300);
    imem_gnt = 1'b1;
    edge1();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("rr_if_valid2", if_valid, 32'd1);
    chk("rr_if_instr", if_instr, 32'h3333_3333);
    chk("rr_if_pc", if_pc, 32'h0040_0300);

    // 5: misaligned PC
    redirect = 1'b1; redirect_pc = 32'h0040_0002;
    edge1();
    redirect = 1'b0; #1;
    chk("t5_no_req", imem_req, 32'd0);
    chk("t5_flushed", if_valid, 32'd0);
    edge1();
    chk("t5_fault", fetch_fault, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0040_0400; #1;
    chk("t5_redir_ignored", pc_wen, 32'd0);
    edge1();
    redirect = 1'b0; #1;
    chk("t5_fault_sticky", fetch_fault, 32'd1);
    chk("t5_pc_hold", pc, 32'h0040_0002);
    chk("t5_no_req2", imem_req, 32'd0);

    // 6: reset mid-read
    reset_n = 1'b0; #1;
    chk("t6_fault_clr", fetch_fault, 32'd0);
    edge1();
    reset_n = 1'b1;
    edge1();
    imem_gnt = 1'b1; #1;
    chk("t6_req", imem_req, 32'd1);
    chk("t6_addr", imem_addr, 32'h0040_0000);
    edge1();
    imem_gnt = 1'b0;
    reset_n = 1'b0; #1;
    chk("t6_rst_valid", if_valid, 32'd0);
    chk("t6_rst_req", imem_req, 32'd0);
    edge1();
    reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    edge1();
    imem_rvalid = 1'b0; #1;
    chk("t6_late_ignored", if_valid, 32'd0);
    chk("t6_restart_req", imem_req, 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0040_0000);
    edge1(); #1;
    chk("t6_still_empty", if_valid, 32'd0);

    // address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    edge1();
    redirect = 1'b0; imem_gnt = 1'b1; #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0000_0000);
    edge1();
    imem_gnt = 1'b0; #1;
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_no_fault", fetch_fault, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
